// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with byte FIFO and polled status register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_ovf;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_tx_nxt;
    logic          w_pop;
    logic          w_last;

`ifdef UART_TX_PARITY_EN
    logic          r_par;
    logic          w_par_nxt;
`endif

    logic          w_wr_data;
    logic          w_wr_stat;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_drop;
    logic [7:0]    w_head;
    logic          w_unused;

    assign w_wr_data = MemWrite && (DataAdr == BASE_ADDR);
    assign w_wr_stat = MemWrite && (DataAdr == STAT_ADDR) && WriteData[2];
    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    // A pop in the same cycle frees the slot, so a push to a full FIFO is kept.
    assign w_push    = w_wr_data && (!w_full || w_pop);
    assign w_drop    = w_wr_data && w_full && !w_pop;
    assign w_head    = r_mem[r_rptr];
    assign w_unused  = ^{WriteData[31:8], WriteData[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_wr_stat)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_par <= 1'b0;
        else        r_par <= w_par_nxt;
    end
`endif

    assign w_last = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        // Every bit state counts down and reloads for the following bit.
        if (r_state != S_IDLE)
            w_cnt_nxt = w_last ? CNT_LOAD : r_cnt - 1'b1;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_cnt_nxt   = CNT_LOAD;
                    w_bit_nxt   = '0;
                    w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = ^w_head;
`endif
                end
            end
            S_START: begin
                if (w_last) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_last) begin
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_last) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_last) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                        w_bit_nxt   = '0;
                        w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                        w_par_nxt   = ^w_head;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The line level is registered from the next state so tx only moves on edges.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign busy     = !w_empty || (r_state != S_IDLE);
    assign ReadData = (DataAdr == STAT_ADDR) ?
                      {29'b0, r_ovf, w_full, busy} : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a line monitor decodes frames and
// compares them against a queue of bytes expected from the stores.
module tb_mmio_uart_tx;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;
    int n_frames = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         st_q[$];

    logic [10:0] m_bits;
    logic [7:0]  m_exp;
    logic        m_ok;
    int          m_st;

    mmio_uart_tx #(
        .BASE_ADDR(32'h0000_0100),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic chk_stat(input string tag, input logic [31:0] exp);
        DataAdr = 32'h104;
        #1;
        chk(tag, ReadData, exp);
        DataAdr = 32'h0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && n_frames < target; i++)
            @(negedge clk);
        chk("frame_count", n_frames, target);
    endtask

    // Single frame from idle: latency, start cycle and busy fall timing.
    task automatic check_single(input logic [7:0] d);
        int c0;
        int idx;
        idx = st_q.size();
        exp_q.push_back(d);
        store(32'h100, {24'h0, d});
        c0 = cyc;
        chk("busy_after_store", busy, 1'b1);
        chk("tx_before_pop", tx, 1'b1);
        @(negedge clk);
        chk("tx_start_low", tx, 1'b0);
        repeat (FRAME - 1) @(negedge clk);
        chk("start_cycle", (st_q.size() > idx) ? st_q[idx] : -1, c0 + 1);
        chk("busy_last_cycle", busy, 1'b1);
        chk("frames_single", n_frames, idx + 1);
        @(negedge clk);
        chk("busy_fall", busy, 1'b0);
        chk("tx_idle", tx, 1'b1);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                m_st   = cyc;
                m_ok   = 1'b1;
                m_bits = '0;
                for (int i = 0; i < NBITS && m_ok; i++) begin
                    repeat ((i == 0) ? HALF : CPB) @(negedge clk);
                    if (rst_n !== 1'b1) m_ok = 1'b0;
                    else                m_bits[i] = tx;
                end
                if (m_ok) begin
                    st_q.push_back(m_st);
                    chk("start_bit", m_bits[0], 1'b0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", {24'h0, m_bits[8:1]}, 32'hFFFF_FFFF);
                        m_exp = m_bits[8:1];
                    end else begin
                        m_exp = exp_q.pop_front();
                        chk("data_byte", m_bits[8:1], m_exp);
                    end
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", m_bits[9], ^m_exp);
`endif
                    chk("stop_bit", m_bits[NBITS-1], 1'b1);
                    n_frames++;
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (50) @(negedge clk);
        chk("idle_tx", tx, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk_stat("idle_status", 32'h0);
        DataAdr = 32'h100;
        #1;
        chk("idle_rd_data_addr", ReadData, 32'h0);
        DataAdr = 32'h0;

        // Single byte 0xA5
        check_single(8'hA5);
        repeat (5) @(negedge clk);

        // Three back-to-back frames
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        store(32'h100, 32'h41);
        store(32'h100, 32'h42);
        store(32'h100, 32'h43);
        wait_frames(4, 3 * FRAME + 20);
        chk("gap_1_2", (st_q.size() > 2) ? st_q[2] - st_q[1] : -1, FRAME);
        chk("gap_2_3", (st_q.size() > 3) ? st_q[3] - st_q[2] : -1, FRAME);
        repeat (5) @(negedge clk);
        chk("busy_after_burst", busy, 1'b0);

        // Overflow: six stores, five sent, sixth dropped
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h61 + 8'(i));
        for (int i = 0; i < 6; i++) store(32'h100, 32'h61 + i);
        chk_stat("status_overflow", 32'h7);
        store(32'h108, 32'h4);
        chk_stat("status_other_addr", 32'h7);
        store(32'h104, 32'h4);
        chk_stat("status_cleared", 32'h3);
        wait_frames(9, 6 * FRAME + 40);
        repeat (5) @(negedge clk);
        chk("busy_after_ovf", busy, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        // Reset mid-frame with two bytes queued
        store(32'h100, 32'h55);
        store(32'h100, 32'h11);
        store(32'h100, 32'h22);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk_stat("rst_status", 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("no_frames_after_rst", n_frames, 9);
        chk("post_rst_tx", tx, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        // 0x07: parity bit is 1 when parity is enabled
        check_single(8'h07);
        chk("queue_empty_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
